// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_reg
//  Purpose  : Elastic valid/ready pipeline stage register for the five-stage
//             MIPS core. It carries instr, pc, a DW-bit payload and the check
//             bit between two adjacent stages. Flush inserts a bubble, which
//             is instr 0, pc PC_RST, data 0 and check 0.
//  Options  : PIPE_SKID_EN -- when defined, a second (skid) entry is added and
//             in_ready comes from a flop, so there is no combinational path
//             from out_ready to in_ready. When undefined, the stage holds one
//             entry and in_ready is combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_reg #(
  parameter int          DW     = 96,
  parameter logic [31:0] PC_RST = 32'h00003000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  input  logic [DW-1:0] in_data,
  input  logic          in_check,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [DW-1:0] out_data,
  output logic          out_check,
  output logic [1:0]    count
);

  // An entry is packed as {instr, pc, data, check}.
  localparam int          c_ew     = 32 + 32 + DW + 1;
  localparam logic [c_ew-1:0] c_bubble = {32'd0, PC_RST, {DW{1'b0}}, 1'b0};

  // Occupancy states. The encoding equals the entry count.
  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_busy  = 2'd1;
  localparam logic [1:0] c_full  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [c_ew-1:0] main_q, main_d;
  logic [c_ew-1:0] w_in_entry;
  logic            w_accept;
  logic            w_retire;

  assign w_in_entry = {in_instr, in_pc, in_data, in_check};
  assign out_valid  = (state_q != c_empty);
  assign w_accept   = in_valid & in_ready;
  assign w_retire   = out_valid & out_ready;

  // The main entry always drives the outputs. It holds the bubble whenever
  // the stage is empty, so no output mux is needed.
  assign {out_instr, out_pc, out_data, out_check} = main_q;

  // Report how many entries the stage holds.
  always_comb begin
    count = 2'd0;
    case (state_q)
      c_busy:  count = 2'd1;
      c_full:  count = 2'd2;
      default: count = 2'd0;
    endcase
  end

`ifdef PIPE_SKID_EN
  logic [c_ew-1:0] skid_q, skid_d;
  logic            in_ready_q, in_ready_d;

  // in_ready comes from a flop, so downstream backpressure cannot ripple
  // combinationally to upstream.
  assign in_ready = in_ready_q;

  // Two-entry next-state logic. FULL never accepts. The skid entry is only
  // filled when downstream stalls while one entry is already held.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = c_empty;
      main_d  = c_bubble;
      skid_d  = c_bubble;
    end else begin
      case (state_q)
        c_empty: begin
          if (w_accept) begin
            main_d  = w_in_entry;
            state_d = c_busy;
          end
        end
        c_busy: begin
          if (w_accept && w_retire) begin
            main_d = w_in_entry;
          end else if (w_accept) begin
            skid_d  = w_in_entry;
            state_d = c_full;
          end else if (w_retire) begin
            main_d  = c_bubble;
            state_d = c_empty;
          end
        end
        c_full: begin
          if (w_retire) begin
            main_d  = skid_q;
            skid_d  = c_bubble;
            state_d = c_busy;
          end
        end
        default: begin
          state_d = c_empty;
          main_d  = c_bubble;
          skid_d  = c_bubble;
        end
      endcase
    end
    in_ready_d = (state_d != c_full);
  end

  // State, entry and in_ready registers. Reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= c_empty;
      main_q     <= c_bubble;
      skid_q     <= c_bubble;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

`else
  // A single entry can take a new one whenever the current one leaves.
  assign in_ready = !out_valid | out_ready;

  // One-entry next-state logic. An accept in BUSY always coincides with a
  // retire because in_ready is low when a held entry is stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = c_empty;
      main_d  = c_bubble;
    end else begin
      case (state_q)
        c_empty: begin
          if (w_accept) begin
            main_d  = w_in_entry;
            state_d = c_busy;
          end
        end
        c_busy: begin
          if (w_accept) begin
            main_d = w_in_entry;
          end else if (w_retire) begin
            main_d  = c_bubble;
            state_d = c_empty;
          end
        end
        default: begin
          state_d = c_empty;
          main_d  = c_bubble;
        end
      endcase
    end
  end

  // State and entry registers. Reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_empty;
      main_q  <= c_bubble;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif

endmodule
`default_nettype wire
